// File: rtl/sld_tap_emu.sv
// sld_tap_emu: emulation of a virtual JTAG node hub. Runs the 16-state TAP
// controller on raw_tck, owns the node instruction register (capture/shift/update)
// and a one-bit bypass register, and steers serial data out on tdo_pin.
module sld_tap_emu #(
    parameter int                      SLD_IR_WIDTH = 4,
    parameter logic [SLD_IR_WIDTH-1:0] TLR_IR_VALUE = '1,
    parameter logic [SLD_IR_WIDTH-1:0] USR1_CODE    = 4'h1
) (
    input  logic                    raw_tck,
    input  logic                    clr,
    input  logic                    tms,
    input  logic                    tdi_pin,
    input  logic                    tdo,
    input  logic [SLD_IR_WIDTH-1:0] ir_out,
    output logic                    jtag_state_tlr,
    output logic                    jtag_state_cdr,
    output logic                    jtag_state_sdr,
    output logic                    jtag_state_e1dr,
    output logic                    jtag_state_udr,
    output logic                    jtag_state_cir,
    output logic                    jtag_state_uir,
    output logic [SLD_IR_WIDTH-1:0] ir_in,
    output logic                    tdi,
    output logic                    usr1,
    output logic                    ena,
    output logic                    tdo_pin
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    tap_state_t              state_q, state_d;
    logic [SLD_IR_WIDTH-1:0] ir_in_q;
    logic [SLD_IR_WIDTH-1:0] sr_q;
    logic                    bypass_q;

    // TAP controller next-state function, one step per edge driven by tms
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // State register plus the IR/bypass datapath actions keyed on the current state;
    // clr wins over everything, including a shift in progress
    always_ff @(posedge raw_tck) begin
        if (clr) begin
            state_q  <= TLR;
            ir_in_q  <= TLR_IR_VALUE;
            sr_q     <= '0;
            bypass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                TLR:      ir_in_q  <= TLR_IR_VALUE;
                CAP_IR:   sr_q     <= ir_out;
                SHIFT_IR: sr_q     <= {tdi_pin, sr_q[SLD_IR_WIDTH-1:1]};
                UPD_IR:   ir_in_q  <= sr_q;
                CAP_DR:   bypass_q <= 1'b0;
                SHIFT_DR: bypass_q <= tdi_pin;
                default:  ;
            endcase
        end
    end

    // One-hot decodes of the registered state for the downstream node
    always_comb begin
        jtag_state_tlr  = (state_q == TLR);
        jtag_state_cdr  = (state_q == CAP_DR);
        jtag_state_sdr  = (state_q == SHIFT_DR);
        jtag_state_e1dr = (state_q == EXIT1_DR);
        jtag_state_udr  = (state_q == UPD_DR);
        jtag_state_cir  = (state_q == CAP_IR);
        jtag_state_uir  = (state_q == UPD_IR);
    end

    // Instruction-derived selects; all-ones means the node is bypassed
    always_comb begin
        ir_in = ir_in_q;
        usr1  = (ir_in_q == USR1_CODE);
        ena   = (ir_in_q != {SLD_IR_WIDTH{1'b1}});
        tdi   = tdi_pin;
    end

    // Serial output mux: IR LSB while shifting IR, node or bypass bit while shifting DR
    always_comb begin
        tdo_pin = 1'b0;
        if (state_q == SHIFT_IR)
            tdo_pin = sr_q[0];
        else if (state_q == SHIFT_DR)
            tdo_pin = ena ? tdo : bypass_q;
    end

endmodule

// File: tb/tb_sld_tap_emu.sv
// Directed bench for sld_tap_emu: reset, IR load, bypass, pause, selected node,
// reset during shift, and five-tms return to TEST_LOGIC_RESET.
module tb_sld_tap_emu;

    logic       raw_tck = 1'b0;
    logic       clr, tms, tdi_pin, tdo;
    logic [3:0] ir_out;
    logic       jtag_state_tlr, jtag_state_cdr, jtag_state_sdr, jtag_state_e1dr;
    logic       jtag_state_udr, jtag_state_cir, jtag_state_uir;
    logic [3:0] ir_in;
    logic       tdi, usr1, ena, tdo_pin;

    int checks = 0;
    int errors = 0;

    sld_tap_emu dut (
        .raw_tck(raw_tck), .clr(clr), .tms(tms), .tdi_pin(tdi_pin), .tdo(tdo),
        .ir_out(ir_out),
        .jtag_state_tlr(jtag_state_tlr), .jtag_state_cdr(jtag_state_cdr),
        .jtag_state_sdr(jtag_state_sdr), .jtag_state_e1dr(jtag_state_e1dr),
        .jtag_state_udr(jtag_state_udr), .jtag_state_cir(jtag_state_cir),
        .jtag_state_uir(jtag_state_uir),
        .ir_in(ir_in), .tdi(tdi), .usr1(usr1), .ena(ena), .tdo_pin(tdo_pin)
    );

    always #5 raw_tck = ~raw_tck;

    // {tlr, cdr, sdr, e1dr, udr, cir, uir}
    wire [6:0] dec = {jtag_state_tlr, jtag_state_cdr, jtag_state_sdr, jtag_state_e1dr,
                      jtag_state_udr, jtag_state_cir, jtag_state_uir};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive tms/tdi, take one edge, settle 1 time unit past it
    task automatic tick(input logic t, input logic d);
        tms = t;
        tdi_pin = d;
        @(posedge raw_tck);
        #1;
    endtask

    // Drive tms/tdi, check the combinational tdo_pin before the edge, then take the edge
    task automatic shift_chk(input string tag, input logic t, input logic d, input logic exp);
        tms = t;
        tdi_pin = d;
        #1;
        check(tag, {31'd0, tdo_pin}, {31'd0, exp});
        @(posedge raw_tck);
        #1;
    endtask

    initial begin
        logic [3:0] tdo_seq;
        clr = 1'b1; tms = 1'b1; tdi_pin = 1'b0; tdo = 1'b0; ir_out = 4'hA;
        @(posedge raw_tck); #1;
        @(posedge raw_tck); #1;

        // Reset state
        check("rst_dec",   {25'd0, dec}, 32'b1000000);
        check("rst_ir_in", {28'd0, ir_in}, 32'hF);
        check("rst_ena",   {31'd0, ena}, 32'd0);
        check("rst_usr1",  {31'd0, usr1}, 32'd0);
        check("rst_tdo",   {31'd0, tdo_pin}, 32'd0);
        clr = 1'b0;

        // IR load: capture 0xA, shift in 1,0,1,0 -> 0x5
        tick(0, 0); check("rti_dec", {25'd0, dec}, 32'd0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0); check("cir_dec", {25'd0, dec}, 32'b0000010);
        tick(0, 0);
        shift_chk("ir_tdo0", 0, 1, 0);
        shift_chk("ir_tdo1", 0, 0, 1);
        shift_chk("ir_tdo2", 0, 1, 0);
        shift_chk("ir_tdo3", 1, 0, 1);
        tick(1, 0); check("uir_dec", {25'd0, dec}, 32'b0000001);
        check("uir_ir_hold", {28'd0, ir_in}, 32'hF);
        tick(0, 0);
        check("ir_load", {28'd0, ir_in}, 32'h5);
        check("ir_ena",  {31'd0, ena}, 32'd1);
        check("ir_usr1", {31'd0, usr1}, 32'd0);

        // Bypass: reset to get ir_in=F, shift 1,1,0 -> 0,1,1
        clr = 1'b1; tick(1, 0); clr = 1'b0;
        check("clr_ir_in", {28'd0, ir_in}, 32'hF);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0); check("cdr_dec", {25'd0, dec}, 32'b0100000);
        tick(0, 0); check("sdr_dec", {25'd0, dec}, 32'b0010000);
        check("byp_ena", {31'd0, ena}, 32'd0);
        shift_chk("byp_tdo0", 0, 1, 0);
        shift_chk("byp_tdo1", 0, 1, 1);
        shift_chk("byp_tdo2", 0, 0, 1);
        shift_chk("byp_tdo3", 1, 1, 0);
        check("e1dr_dec", {25'd0, dec}, 32'b0001000);
        check("e1dr_tdo", {31'd0, tdo_pin}, 32'd0);

        // Pause: bypass bit (1) must survive PAUSE_DR for 3 edges
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        check("pause_sdr", {25'd0, dec}, 32'b0010000);
        shift_chk("pause_tdo0", 0, 0, 1);
        shift_chk("pause_tdo1", 1, 0, 0);
        tick(1, 0); check("udr_dec", {25'd0, dec}, 32'b0000100);
        tick(0, 0);

        // Selected node: load USR1 (shift 1,0,0,0), then DR passes tdo through
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        check("usr_ir_in", {28'd0, ir_in}, 32'h1);
        check("usr_usr1",  {31'd0, usr1}, 32'd1);
        check("usr_ena",   {31'd0, ena}, 32'd1);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        check("usr_sdr", {25'd0, dec}, 32'b0010000);
        tdo_seq = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            tdo = tdo_seq[i];
            shift_chk($sformatf("usr_tdo%0d", i), 0, 0, tdo_seq[i]);
        end
        tdo = 1'b0;
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);

        // Reset during SHIFT_IR after two bits, then a clean IR load of 0x6
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        tick(0, 1);
        clr = 1'b1; tick(0, 1); clr = 1'b0;
        check("mid_dec",   {25'd0, dec}, 32'b1000000);
        check("mid_ir_in", {28'd0, ir_in}, 32'hF);
        check("mid_tdo",   {31'd0, tdo_pin}, 32'd0);
        ir_out = 4'h3;
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        shift_chk("mid_tdo0", 0, 0, 1);
        shift_chk("mid_tdo1", 0, 1, 1);
        shift_chk("mid_tdo2", 0, 1, 0);
        shift_chk("mid_tdo3", 1, 0, 0);
        tick(1, 0);
        tick(0, 0);
        check("mid_reload", {28'd0, ir_in}, 32'h6);
        check("mid_ena",    {31'd0, ena}, 32'd1);

        // Five tms=1 edges from RTI reach TLR and restore ir_in
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("tlr5_dec",   {25'd0, dec}, 32'b1000000);
        check("tlr5_ir_in", {28'd0, ir_in}, 32'hF);
        check("tlr5_ena",   {31'd0, ena}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sld_tap_emu.md
SLD_TAP_EMU -- requirements
Module: sld_tap_emu

Interface
REQ-001 The block SHALL have parameter SLD_IR_WIDTH, default 4, setting the width of the node instruction register.
REQ-002 The block SHALL have parameter TLR_IR_VALUE, default all-ones, giving the ir_in value loaded in reset and in TEST_LOGIC_RESET.
REQ-003 The block SHALL have parameter USR1_CODE, default 4'h1, giving the ir_in code that asserts usr1.
REQ-004 The block SHALL have port raw_tck, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port tms, input, 1 bit: test mode select.
REQ-007 The block SHALL have port tdi_pin, input, 1 bit: serial data in.
REQ-008 The block SHALL have port tdo, input, 1 bit: serial data returned by the downstream node.
REQ-009 The block SHALL have port ir_out, input, SLD_IR_WIDTH bits: node status captured in CAPTURE_IR.
REQ-010 The block SHALL have ports jtag_state_tlr, jtag_state_cdr, jtag_state_sdr, jtag_state_e1dr, jtag_state_udr, jtag_state_cir and jtag_state_uir, each an output of 1 bit, each a one-hot state decode.
REQ-011 The block SHALL have port ir_in, output, SLD_IR_WIDTH bits: the updated node instruction.
REQ-012 The block SHALL have port tdi, output, 1 bit: combinational copy of tdi_pin to the node.
REQ-013 The block SHALL have port usr1, output, 1 bit: high when ir_in == USR1_CODE.
REQ-014 The block SHALL have port ena, output, 1 bit: high when ir_in != all-ones (node selected, not BYPASS).
REQ-015 The block SHALL have port tdo_pin, output, 1 bit: serial data out.

Function
REQ-016 The block SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing one state per raw_tck edge as a function of tms.
REQ-017 FSM transitions SHALL be (tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SHIFT_x / EXIT1_x
  - SHIFT_x: SHIFT_x / EXIT1_x
  - EXIT1_x: PAUSE_x / UPD_x
  - PAUSE_x: PAUSE_x / EXIT2_x
  - EXIT2_x: SHIFT_x / UPD_x
  - UPD_x: RTI / SEL_DR
REQ-018 Five consecutive edges with tms=1 SHALL reach TLR from any state.
REQ-019 jtag_state_* SHALL decode the registered state combinationally: exactly one asserted when the state is its named state, none otherwise.
REQ-020 On an edge with state CAP_IR, the IR shift register SHALL load ir_out.
REQ-021 On an edge with state SHIFT_IR, the IR shift register SHALL load {tdi_pin, sr[W-1:1]} (LSB-first shift).
REQ-022 On an edge with state UPD_IR, ir_in SHALL load the IR shift register, visible in the following cycle.
REQ-023 On an edge with state TLR, ir_in SHALL load TLR_IR_VALUE.
REQ-024 The bypass bit SHALL clear on an edge with state CAP_DR and load tdi_pin on an edge with state SHIFT_DR.
REQ-025 tdo_pin SHALL be combinational:
  - in SHIFT_IR: sr[0]
  - in SHIFT_DR with ena=1: tdo
  - in SHIFT_DR with ena=0: bypass bit
  - in any other state: 0
REQ-026 In PAUSE and EXIT states, the shift register and bypass bit SHALL hold.
REQ-027 usr1 and ena SHALL derive only from registered ir_in, with no added latency.

Reset
REQ-028 When clr=1 on an edge, the block SHALL set state to TLR, ir_in to TLR_IR_VALUE, the shift register to 0 and bypass to 0, overriding tms and any in-progress shift.
REQ-029 After reset, outputs SHALL be: jtag_state_tlr=1, other jtag_state_* 0, ena=0, usr1=0 (defaults) and tdo_pin=0.
REQ-030 Reset SHALL take effect on the same edge as clr=1, with no recovery cycle: the first edge with clr=0 advances the FSM normally.

Verification
REQ-031 From RTI, the bench SHALL drive tms=1 for 5 edges -> jtag_state_tlr=1 after the 5th edge and ir_in=4'hF.
REQ-032 IR load scenario:
  - stimulus: after reset, tms 0,1,1,0,0 reaching SHIFT_IR with ir_out=4'hA captured; then tdi_pin 1,0,1,0 with tms 0,0,0,1; then tms 1,0
  - response: tdo_pin shows 0,1,0,1 during the shift; ir_in=4'h5 after UPD_IR; ena=1, usr1=0.
REQ-033 Bypass scenario: with ir_in=4'hF, enter SHIFT_DR and shift tdi_pin 1,1,0 -> tdo_pin = 0,1,1 (one-cycle delay); ena=0.
REQ-034 Selected-node scenario: with ir_in=USR1_CODE, SHIFT_DR with tdo toggling -> tdo_pin equals tdo each cycle; usr1=1; jtag_state_sdr=1.
REQ-035 Reset-mid-shift scenario: assert clr during SHIFT_IR after 2 bits shifted -> next cycle jtag_state_tlr=1, ir_in=4'hF, tdo_pin=0; the following IR load completes correctly.
REQ-036 Pause scenario: PAUSE_DR held for 3 edges between shifts -> bypass bit unchanged; EXIT2_DR then tms=0 resumes shifting.
